// File: rtl/str_tgc_pkg.sv
// Shared types and helpers for the stream traffic generator/checker:
// pattern modes, TX FSM encoding, LFSR step functions and saturating increment.
package str_tgc_pkg;

  typedef enum logic {
    MODE_CNT  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  // Galois taps for x^32+x^22+x^2+x+1 and x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [31:0] LFSR32_POLY = 32'h8020_0003;
  localparam logic [15:0] LFSR16_POLY = 16'hB400;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_RUN   = 2'd1;
  localparam tx_state_t ST_DRAIN = 2'd2;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR32_POLY : 32'h0);
  endfunction

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR16_POLY : 16'h0);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/str_tgc_if.sv
// valid/ready/last stream bundle; master drives data, slave drives ready.
interface str_tgc_if #(
  parameter int DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/str_tgc_pat.sv
// Pattern engine: beat index / 32-bit LFSR data plus packet beat counter for tlast.
// Used both as the TX generator and as the RX expected-value model.
module str_tgc_pat
  import str_tgc_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  mode_e         mode,
  input  logic [LW-1:0] len,
  output logic [DW-1:0] data,
  output logic          last
);

  logic [DW-1:0] idx_q, idx_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [LW-1:0] pkt_q, pkt_d;
  logic [LW-1:0] last_idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data     = '0;
    last_idx = (len == '0) ? '0 : len - LW'(1);
    // >= keeps the packet counter bounded even if it was left beyond a shorter length
    last     = (pkt_q >= last_idx);
    for (int i = 0; i < DW; i++) begin
      data[i] = (mode == MODE_LFSR) ? lfsr_q[i % 32] : idx_q[i];
    end

    idx_d  = idx_q;
    lfsr_d = lfsr_q;
    pkt_d  = pkt_q;
    if (clr) begin
      idx_d  = '0;
      lfsr_d = 32'h1;
      pkt_d  = '0;
    end else if (adv) begin
      idx_d  = idx_q + DW'(1);
      lfsr_d = lfsr32_next(lfsr_q);
      pkt_d  = last ? '0 : pkt_q + LW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      lfsr_q <= 32'h1;
      pkt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
      pkt_q  <= pkt_d;
    end
  end

endmodule

// File: rtl/str_tgc.sv
// Stream traffic generator + checker: throttled TX pattern source and throttled RX
// sink that compares every accepted beat against an identical pattern engine.
module str_tgc
  import str_tgc_pkg::*;
#(
  parameter int          DW   = 32,
  parameter int          LW   = 16,
  parameter logic [31:0] SEED = 32'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_clr,
  input  logic          cfg_mode,
  input  logic [LW-1:0] cfg_len,
  input  logic [3:0]    cfg_vrate,
  input  logic [3:0]    cfg_rrate,
  str_tgc_if.master     tx,
  str_tgc_if.slave      rx,
  output logic [31:0]   tx_cnt,
  output logic [31:0]   rx_cnt,
  output logic [31:0]   err_cnt,
  output logic          err,
  output logic          busy
);

  // The throttle LFSRs are 16 bits wide; an all-zero seed would lock them up
  localparam logic [15:0] SEED16 = (SEED[15:0] != 16'h0) ? SEED[15:0] : 16'h1;

  tx_state_t     state_q, state_d;
  logic          tvalid_q, tvalid_d;
  logic          rready_q, rready_d;
  logic [15:0]   tx_lfsr_q, tx_lfsr_d;
  logic [15:0]   rx_lfsr_q, rx_lfsr_d;
  logic [31:0]   tx_cnt_q, tx_cnt_d;
  logic [31:0]   rx_cnt_q, rx_cnt_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic          err_q, err_d;

  logic          tx_beat, rx_beat, vslot, mismatch;
  logic [DW-1:0] tx_pdata, exp_data;
  logic          tx_plast, exp_last;

  assign tx_beat  = tvalid_q & tx.tready;
  assign rx_beat  = rx.tvalid & rready_q;
  assign mismatch = (rx.tdata != exp_data) | (rx.tlast != exp_last);

  str_tgc_pat #(.DW(DW), .LW(LW)) u_tx_pat (
    .clk (clk), .rst (rst), .clr (cfg_clr), .adv (tx_beat),
    .mode(mode_e'(cfg_mode)), .len (cfg_len), .data(tx_pdata), .last(tx_plast)
  );

  str_tgc_pat #(.DW(DW), .LW(LW)) u_rx_pat (
    .clk (clk), .rst (rst), .clr (cfg_clr), .adv (rx_beat),
    .mode(mode_e'(cfg_mode)), .len (cfg_len), .data(exp_data), .last(exp_last)
  );

  always_comb begin
    tx_lfsr_d = lfsr16_next(tx_lfsr_q);
    rx_lfsr_d = lfsr16_next(rx_lfsr_q);
    rready_d  = (rx_lfsr_q[3:0] >= cfg_rrate);
    vslot     = (tx_lfsr_q[3:0] >= cfg_vrate);

    state_d  = state_q;
    tvalid_d = tvalid_q;
    case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        if (cfg_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_en) begin
          // An offered beat must complete before the generator can go idle
          tvalid_d = tvalid_q & ~tx_beat;
          state_d  = tvalid_d ? ST_DRAIN : ST_IDLE;
        end else begin
          tvalid_d = (tvalid_q & ~tx_beat) | vslot;
        end
      end
      ST_DRAIN: begin
        if (tx_beat) begin
          tvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    tx_cnt_d  = tx_beat ? sat_inc32(tx_cnt_q) : tx_cnt_q;
    rx_cnt_d  = rx_beat ? sat_inc32(rx_cnt_q) : rx_cnt_q;
    err_cnt_d = (rx_beat && mismatch) ? sat_inc32(err_cnt_q) : err_cnt_q;
    err_d     = err_q | (rx_beat & mismatch);
    if (cfg_clr) begin
      tx_cnt_d  = '0;
      rx_cnt_d  = '0;
      err_cnt_d = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      tx_lfsr_q <= SEED16;
      rx_lfsr_q <= SEED16;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tvalid_q  <= tvalid_d;
      rready_q  <= rready_d;
      tx_lfsr_q <= tx_lfsr_d;
      rx_lfsr_q <= rx_lfsr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
    end
  end

  assign tx.tvalid = tvalid_q;
  assign tx.tdata  = tvalid_q ? tx_pdata : '0;
  assign tx.tlast  = tvalid_q & tx_plast;
  assign rx.tready = rready_q;
  assign tx_cnt    = tx_cnt_q;
  assign rx_cnt    = rx_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
